// File: rtl/gol_engine_pkg.sv
// Shared types and index helpers for the Game-of-Life engine.
package gol_engine_pkg;

    typedef enum logic {
        GOL_S_HALT = 1'b0,
        GOL_S_RUN  = 1'b1
    } gol_state_e;

    localparam int GOL_NB_N = 8;

    function automatic int cell_idx(input int r, input int c, input int w);
        return r * w + c;
    endfunction

    // Maps -1..n onto 0..n-1 for toroidal neighbour lookup.
    function automatic int wrap_idx(input int v, input int n);
        return (v + n) % n;
    endfunction

endpackage

// File: rtl/gol_cell_next.sv
// One cell's next state from itself and its eight neighbours.
module gol_cell_next
    import gol_engine_pkg::*;
(
    input  logic                i_self,
    input  logic [GOL_NB_N-1:0] i_nb,
    output logic                o_next
);

    logic [3:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < GOL_NB_N; i++) begin
            w_cnt = w_cnt + {3'b000, i_nb[i]};
        end
    end

    assign o_next = (w_cnt == 4'd3) || (i_self && (w_cnt == 4'd2));

endmodule

// File: rtl/gol_engine.sv
// Parametrised W x H Game-of-Life engine with run/halt/step/load control.
// Define GOL_TORUS_EN for toroidal edges; otherwise off-grid cells are dead.
module gol_engine
    import gol_engine_pkg::*;
#(
    parameter int             W           = 8,
    parameter int             H           = 8,
    parameter int             TICK_DIV    = 2000000,
    parameter int             GEN_W       = 16,
    parameter logic [W*H-1:0] INIT        = '0,
    parameter int             STOP_STABLE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_load,
    input  logic [W*H-1:0]   i_pattern,
    output logic [W*H-1:0]   o_cells,
    output logic [GEN_W-1:0] o_gen,
    output logic             o_tick,
    output logic             o_stable,
    output logic             o_empty,
    output logic             o_state
);

    localparam int             CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [W*H-1:0]   r_cells;
    logic [GEN_W-1:0] r_gen;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_hold;
    gol_state_e       r_state;

    logic [W*H-1:0]   w_next;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_advance;
    logic             w_hold_nxt;
    logic             w_stable;
    gol_state_e       w_state_nxt;

    genvar gr, gc, gk;
    generate
        for (gr = 0; gr < H; gr++) begin : g_row
            for (gc = 0; gc < W; gc++) begin : g_col
                // Neighbourhood laid out row-major, index 4 is the cell itself.
                logic [8:0] w_nbhd;
                for (gk = 0; gk < 9; gk++) begin : g_nb
                    localparam int RR = gr + gk / 3 - 1;
                    localparam int CC = gc + gk % 3 - 1;
`ifdef GOL_TORUS_EN
                    localparam int IDX = cell_idx(wrap_idx(RR, H), wrap_idx(CC, W), W);
                    assign w_nbhd[gk] = r_cells[IDX];
`else
                    if (RR >= 0 && RR < H && CC >= 0 && CC < W) begin : g_in
                        localparam int IDX = cell_idx(RR, CC, W);
                        assign w_nbhd[gk] = r_cells[IDX];
                    end else begin : g_out
                        assign w_nbhd[gk] = 1'b0;
                    end
`endif
                end
                gol_cell_next u_cell (
                    .i_self (w_nbhd[4]),
                    .i_nb   ({w_nbhd[8:5], w_nbhd[3:0]}),
                    .o_next (w_next[gr*W+gc])
                );
            end
        end
    endgenerate

    assign w_stable = (w_next == r_cells);

    // r_hold keeps an auto-stopped engine halted until i_run is released.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_advance   = 1'b0;
        w_hold_nxt  = r_hold & i_run;
        if (i_load) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                GOL_S_HALT: begin
                    if (i_run && !r_hold) begin
                        w_state_nxt = GOL_S_RUN;
                        w_cnt_nxt   = '0;
                    end else if (i_step) begin
                        w_advance = 1'b1;
                    end
                end
                GOL_S_RUN: begin
                    if (!i_run) begin
                        w_state_nxt = GOL_S_HALT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_advance = 1'b1;
                        w_cnt_nxt = '0;
                        if (STOP_STABLE != 0 && w_stable) begin
                            w_state_nxt = GOL_S_HALT;
                            w_hold_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = GOL_S_HALT;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= GOL_S_HALT;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_tick  <= w_advance;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cells <= INIT;
            r_gen   <= '0;
        end else if (i_load) begin
            r_cells <= i_pattern;
            r_gen   <= '0;
        end else if (w_advance) begin
            r_cells <= w_next;
            r_gen   <= r_gen + 1'b1;
        end
    end

    assign o_cells  = r_cells;
    assign o_gen    = r_gen;
    assign o_tick   = r_tick;
    assign o_stable = w_stable;
    assign o_empty  = (r_cells == '0);
    assign o_state  = r_state;

endmodule

// File: tb/tb_gol_engine.sv
// Directed-vector bench for gol_engine: 8x8, TICK_DIV=4, STOP_STABLE=1.
module tb_gol_engine;

    localparam int W = 8;
    localparam int H = 8;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
    localparam logic [63:0] SINGLE  = 64'h0000_0010_0000_0000;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_00E0_2040;
    localparam logic [63:0] ROW0    = 64'h0000_0000_0000_00E0;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_run = 1'b0;
    logic          i_step = 1'b0;
    logic          i_load = 1'b0;
    logic [63:0]   i_pattern = '0;
    logic [63:0]   o_cells;
    logic [15:0]   o_gen;
    logic          o_tick;
    logic          o_stable;
    logic          o_empty;
    logic          o_state;

    int n_checks = 0;
    int n_errors = 0;

    gol_engine #(
        .W(W), .H(H), .TICK_DIV(4), .GEN_W(16), .INIT('0), .STOP_STABLE(1)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
        .i_load(i_load), .i_pattern(i_pattern), .o_cells(o_cells), .o_gen(o_gen),
        .o_tick(o_tick), .o_stable(o_stable), .o_empty(o_empty), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Returns the number of edges until o_tick is seen; 0 on timeout.
    task automatic wait_tick(output int ncyc);
        ncyc = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (o_tick) begin
                ncyc = i;
                break;
            end
        end
        if (ncyc == 0) chk("tick_timeout", 64'd0, 64'd1);
    endtask

    task automatic load(input logic [63:0] pat);
        i_pattern = pat;
        i_load    = 1'b1;
        cyc();
        i_load    = 1'b0;
    endtask

    int n;
    int ticks;

    initial begin
        // Reset state
        #2;
        chk("rst_cells", o_cells, 64'd0);
        chk("rst_gen", {48'd0, o_gen}, 64'd0);
        chk("rst_tick", {63'd0, o_tick}, 64'd0);
        chk("rst_empty", {63'd0, o_empty}, 64'd1);
        chk("rst_stable", {63'd0, o_stable}, 64'd1);
        chk("rst_state", {63'd0, o_state}, 64'd0);
        cyc(2);
        i_reset = 1'b0;
        cyc();

        // Blinker in RUN
        load(BLINK_H);
        chk("blk_load", o_cells, BLINK_H);
        chk("blk_stable0", {63'd0, o_stable}, 64'd0);
        i_run = 1'b1;
        wait_tick(n);
        chk("blk_lat1", n, 64'd5);
        chk("blk_cells1", o_cells, BLINK_V);
        chk("blk_gen1", {48'd0, o_gen}, 64'd1);
        chk("blk_stable1", {63'd0, o_stable}, 64'd0);
        cyc();
        chk("blk_tick_pulse", {63'd0, o_tick}, 64'd0);
        wait_tick(n);
        chk("blk_lat2", n, 64'd3);
        chk("blk_cells2", o_cells, BLINK_H);
        chk("blk_gen2", {48'd0, o_gen}, 64'd2);
        wait_tick(n);
        chk("blk_lat3", n, 64'd4);
        chk("blk_cells3", o_cells, BLINK_V);
        chk("blk_gen3", {48'd0, o_gen}, 64'd3);
        i_run = 1'b0;
        cyc();
        chk("blk_halt", {63'd0, o_state}, 64'd0);

        // Still life and single step
        load(BLOCK);
        chk("sl_stable", {63'd0, o_stable}, 64'd1);
        chk("sl_empty", {63'd0, o_empty}, 64'd0);
        chk("sl_tick_before", {63'd0, o_tick}, 64'd0);
        i_step = 1'b1;
        cyc();
        i_step = 1'b0;
        chk("sl_cells", o_cells, BLOCK);
        chk("sl_gen", {48'd0, o_gen}, 64'd1);
        chk("sl_tick", {63'd0, o_tick}, 64'd1);
        cyc();
        chk("sl_tick_end", {63'd0, o_tick}, 64'd0);
        i_step = 1'b1;
        cyc(3);
        i_step = 1'b0;
        chk("sl_step_held", {48'd0, o_gen}, 64'd4);

        // Auto-halt on a stable grid
        load(SINGLE);
        i_run = 1'b1;
        wait_tick(n);
        chk("ss_cells1", o_cells, 64'd0);
        chk("ss_empty1", {63'd0, o_empty}, 64'd1);
        chk("ss_gen1", {48'd0, o_gen}, 64'd1);
        wait_tick(n);
        chk("ss_gen2", {48'd0, o_gen}, 64'd2);
        chk("ss_state", {63'd0, o_state}, 64'd0);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (o_tick) ticks++;
        end
        chk("ss_no_tick", ticks, 64'd0);
        chk("ss_still_halt", {63'd0, o_state}, 64'd0);
        i_run = 1'b0;
        cyc();
        i_run = 1'b1;
        cyc();
        chk("ss_restart", {63'd0, o_state}, 64'd1);
        i_run = 1'b0;
        cyc();

        // Glider, 32 generations via a held step
        load(GLIDER);
        i_step = 1'b1;
        cyc(32);
        i_step = 1'b0;
        chk("gl_gen", {48'd0, o_gen}, 64'd32);
`ifdef GOL_TORUS_EN
        chk("gl_cells", o_cells, GLIDER);
`else
        chk("gl_stable", {63'd0, o_stable}, 64'd1);
        chk("gl_pop", $countones(o_cells), 64'd4);
`endif

        // Load mid-interval restarts the tick interval
        load(BLINK_H);
        i_run = 1'b1;
        wait_tick(n);
        chk("ml_gen_pre", {48'd0, o_gen}, 64'd1);
        cyc(2);
        load(BLINK_H);
        chk("ml_gen0", {48'd0, o_gen}, 64'd0);
        chk("ml_cells", o_cells, BLINK_H);
        chk("ml_state", {63'd0, o_state}, 64'd1);
        wait_tick(n);
        chk("ml_interval", n, 64'd4);
        chk("ml_gen1", {48'd0, o_gen}, 64'd1);
        i_run = 1'b0;
        cyc();

        // Load and step together in HALT: load only
        i_pattern = ROW0;
        i_load    = 1'b1;
        i_step    = 1'b1;
        cyc();
        i_load    = 1'b0;
        i_step    = 1'b0;
        chk("ls_cells", o_cells, ROW0);
        chk("ls_gen", {48'd0, o_gen}, 64'd0);
        chk("ls_tick", {63'd0, o_tick}, 64'd0);

        // Asynchronous reset between edges during RUN
        i_run = 1'b1;
        cyc(6);
        chk("ar_running", {63'd0, o_state}, 64'd1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("ar_cells", o_cells, 64'd0);
        chk("ar_gen", {48'd0, o_gen}, 64'd0);
        chk("ar_tick", {63'd0, o_tick}, 64'd0);
        chk("ar_state", {63'd0, o_state}, 64'd0);
        i_run = 1'b0;
        cyc();
        i_reset = 1'b0;
        cyc();
        chk("ar_released", {63'd0, o_state}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
